// File: rtl/alu_pkg.sv
// Shared definitions for the ALU / multiply-divide unit: default widths,
// function codes, FSM state encoding and the control bundle that the
// sign-correction step needs.
package alu_pkg;

  localparam int BITS_SIZE_DEF  = 32;
  localparam int BITS_SHAMT_DEF = 5;
  localparam int BITS_OP_DEF    = 6;

  // Function codes
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  // Control FSM encoding
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_FIX  = 2'b10;

  // Everything the FIX step needs to turn magnitudes back into HI/LO
  typedef struct packed {
    logic is_div;   // 1 = divide, 0 = multiply
    logic neg_res;  // product / quotient must be negated
    logic neg_a;    // dividend was negative (remainder takes its sign)
    logic div0;     // divisor was zero
  } md_ctl_t;

  // True for the four iterative operations
  function automatic logic fn_is_muldiv(input logic [5:0] op);
    return (op == FN_MULT) || (op == FN_MULTU) || (op == FN_DIV) || (op == FN_DIVU);
  endfunction

  // True for the signed flavours of multiply / divide
  function automatic logic fn_is_signed_md(input logic [5:0] op);
    return (op == FN_MULT) || (op == FN_DIV);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned multiplier / restoring divider working on operand
// magnitudes. One iteration per clock, BITS_SIZE iterations per operation.
// Multiply: {hi,lo} holds the running product, multiplier shifts out of lo.
// Divide:   hi holds the partial remainder, dividend shifts out of lo and the
//           quotient bits shift into lo.
module muldiv_core
  import alu_pkg::*;
#(
  parameter int BITS_SIZE  = BITS_SIZE_DEF,
  parameter int BITS_SHAMT = BITS_SHAMT_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_div,
  input  logic [BITS_SIZE-1:0] i_mag_a,
  input  logic [BITS_SIZE-1:0] i_mag_b,
  output logic                 o_done,
  output logic [BITS_SIZE-1:0] o_hi,
  output logic [BITS_SIZE-1:0] o_lo
);

  localparam logic [BITS_SHAMT-1:0] LAST_CNT = BITS_SHAMT'(BITS_SIZE - 1);

  logic                  busy_q, busy_d;
  logic                  div_q, div_d;
  logic [BITS_SHAMT-1:0] cnt_q, cnt_d;
  logic [BITS_SIZE-1:0]  hi_q, hi_d;
  logic [BITS_SIZE-1:0]  lo_q, lo_d;
  logic [BITS_SIZE-1:0]  opnd_q, opnd_d;
  logic [BITS_SIZE:0]    add_sum_s;
  logic [BITS_SIZE:0]    shifted_s;
  logic [BITS_SIZE:0]    diff_s;

  // Final iteration happens on the coming edge
  assign o_done = busy_q && (cnt_q == LAST_CNT);
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

  // One shift-add or restoring-subtract step, plus operand load on start
  always_comb begin
    busy_d    = busy_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    add_sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(BITS_SIZE+1){1'b0}});
    shifted_s = {hi_q, lo_q[BITS_SIZE-1]};
    diff_s    = shifted_s - {1'b0, opnd_q};
    if (i_start) begin
      busy_d = 1'b1;
      div_d  = i_div;
      cnt_d  = '0;
      hi_d   = '0;
      lo_d   = i_mag_a;
      opnd_d = i_mag_b;
    end else if (busy_q) begin
      if (div_q) begin
        if (!diff_s[BITS_SIZE]) begin
          hi_d = diff_s[BITS_SIZE-1:0];
          lo_d = {lo_q[BITS_SIZE-2:0], 1'b1};
        end else begin
          hi_d = shifted_s[BITS_SIZE-1:0];
          lo_d = {lo_q[BITS_SIZE-2:0], 1'b0};
        end
      end else begin
        hi_d = add_sum_s[BITS_SIZE:1];
        lo_d = {add_sum_s[0], lo_q[BITS_SIZE-1:1]};
      end
      cnt_d  = cnt_q + 1'b1;
      busy_d = (cnt_q != LAST_CNT);
    end else begin
      busy_d = 1'b0;
    end
  end

  // Datapath and iteration counter registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// MIPS-style ALU with HI/LO multiply/divide. Single-cycle operations answer
// on the edge that accepts them; MULT/DIV run in muldiv_core under an
// IDLE -> CALC -> FIX control FSM and answer with the new LO.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int BITS_SIZE  = BITS_SIZE_DEF,
  parameter int BITS_SHAMT = BITS_SHAMT_DEF,
  parameter int BITS_OP    = BITS_OP_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [BITS_OP-1:0]    i_op,
  input  logic [BITS_SIZE-1:0]  i_data_a,
  input  logic [BITS_SIZE-1:0]  i_data_b,
  input  logic [BITS_SHAMT-1:0] i_alu_shamt,
  input  logic                  i_flag_shamt,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [BITS_SIZE-1:0]  o_result,
  output logic                  o_alu_zero
);

  logic [1:0]            state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic                  zero_q, zero_d;
  logic [BITS_SIZE-1:0]  result_q, result_d;
  logic [BITS_SIZE-1:0]  hi_q, hi_d;
  logic [BITS_SIZE-1:0]  lo_q, lo_d;
  logic [BITS_SIZE-1:0]  a_q, a_d;
  md_ctl_t               ctl_q, ctl_d;

  logic [5:0]            op_s;
  logic                  accept_s;
  logic                  is_md_s;
  logic                  is_signed_s;
  logic [BITS_SHAMT-1:0] shamt_s;
  logic [BITS_SIZE-1:0]  alu_res_s;
  logic [BITS_SIZE-1:0]  mag_a_s, mag_b_s;
  logic                  core_start_s;
  logic                  core_done_s;
  logic [BITS_SIZE-1:0]  core_hi_s, core_lo_s;
  logic [2*BITS_SIZE-1:0] prod_s;
  logic [BITS_SIZE-1:0]  fix_hi_s, fix_lo_s;

  assign op_s        = 6'(i_op);
  assign accept_s    = i_valid && ready_q;
  assign is_md_s     = fn_is_muldiv(op_s);
  assign is_signed_s = fn_is_signed_md(op_s);
  assign shamt_s     = i_flag_shamt ? i_alu_shamt : i_data_a[BITS_SHAMT-1:0];

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_result   = result_q;
  assign o_alu_zero = zero_q;

  // Single-cycle result selection; unknown codes produce zero
  always_comb begin
    alu_res_s = '0;
    case (op_s)
      FN_ADD:  alu_res_s = i_data_a + i_data_b;
      FN_SUB:  alu_res_s = i_data_a - i_data_b;
      FN_AND:  alu_res_s = i_data_a & i_data_b;
      FN_OR:   alu_res_s = i_data_a | i_data_b;
      FN_XOR:  alu_res_s = i_data_a ^ i_data_b;
      FN_NOR:  alu_res_s = ~(i_data_a | i_data_b);
      FN_SLT:  alu_res_s = {{(BITS_SIZE-1){1'b0}}, ($signed(i_data_a) < $signed(i_data_b))};
      FN_SLTU: alu_res_s = {{(BITS_SIZE-1){1'b0}}, (i_data_a < i_data_b)};
      FN_SLL:  alu_res_s = i_data_b << shamt_s;
      FN_SRL:  alu_res_s = i_data_b >> shamt_s;
      FN_SRA:  alu_res_s = $signed(i_data_b) >>> shamt_s;
      FN_MFHI: alu_res_s = hi_q;
      FN_MFLO: alu_res_s = lo_q;
      default: alu_res_s = '0;
    endcase
  end

  // Operand magnitudes handed to the iterative core
  always_comb begin
    if (is_signed_s && i_data_a[BITS_SIZE-1]) begin
      mag_a_s = -i_data_a;
    end else begin
      mag_a_s = i_data_a;
    end
    if (is_signed_s && i_data_b[BITS_SIZE-1]) begin
      mag_b_s = -i_data_b;
    end else begin
      mag_b_s = i_data_b;
    end
  end

  // Sign correction of the core's magnitude result into final HI/LO
  always_comb begin
    prod_s = {core_hi_s, core_lo_s};
    if (ctl_q.is_div) begin
      if (ctl_q.div0) begin
        fix_hi_s = a_q;
        fix_lo_s = '1;
      end else begin
        fix_lo_s = ctl_q.neg_res ? -core_lo_s : core_lo_s;
        fix_hi_s = ctl_q.neg_a   ? -core_hi_s : core_hi_s;
      end
    end else begin
      if (ctl_q.neg_res) begin
        prod_s = -prod_s;
      end else begin
        prod_s = prod_s;
      end
      fix_hi_s = prod_s[2*BITS_SIZE-1:BITS_SIZE];
      fix_lo_s = prod_s[BITS_SIZE-1:0];
    end
  end

  // Control FSM and result/HI/LO next-state logic
  always_comb begin
    state_d      = state_q;
    valid_d      = 1'b0;
    zero_d       = zero_q;
    result_d     = result_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    a_d          = a_q;
    ctl_d        = ctl_q;
    core_start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (is_md_s) begin
            core_start_s  = 1'b1;
            state_d       = ST_CALC;
            a_d           = i_data_a;
            ctl_d.is_div  = op_s[1];
            ctl_d.neg_a   = is_signed_s && i_data_a[BITS_SIZE-1];
            ctl_d.neg_res = is_signed_s && (i_data_a[BITS_SIZE-1] ^ i_data_b[BITS_SIZE-1]);
            ctl_d.div0    = (i_data_b == '0);
          end else begin
            valid_d  = 1'b1;
            result_d = alu_res_s;
            zero_d   = (alu_res_s == '0);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (core_done_s) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_FIX: begin
        hi_d     = fix_hi_s;
        lo_d     = fix_lo_s;
        result_d = fix_lo_s;
        zero_d   = (fix_lo_s == '0);
        valid_d  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // State, HI/LO and registered outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      zero_q   <= 1'b1;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      a_q      <= '0;
      ctl_q    <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      a_q      <= a_d;
      ctl_q    <= ctl_d;
    end
  end

  muldiv_core #(
    .BITS_SIZE  (BITS_SIZE),
    .BITS_SHAMT (BITS_SHAMT)
  ) u_core (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (core_start_s),
    .i_div   (op_s[1]),
    .i_mag_a (mag_a_s),
    .i_mag_b (mag_b_s),
    .o_done  (core_done_s),
    .o_hi    (core_hi_s),
    .o_lo    (core_lo_s)
  );

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_muldiv;

  logic        i_clk;
  logic        i_reset;
  logic        i_valid;
  logic [5:0]  i_op;
  logic [31:0] i_data_a;
  logic [31:0] i_data_b;
  logic [4:0]  i_alu_shamt;
  logic        i_flag_shamt;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_result;
  logic        o_alu_zero;

  int checks;
  int errors;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  alu_muldiv #(
    .BITS_SIZE  (32),
    .BITS_SHAMT (5),
    .BITS_OP    (6)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .i_op         (i_op),
    .i_data_a     (i_data_a),
    .i_data_b     (i_data_b),
    .i_alu_shamt  (i_alu_shamt),
    .i_flag_shamt (i_flag_shamt),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .o_result     (o_result),
    .o_alu_zero   (o_alu_zero)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on the architectural HI/LO state
  function automatic logic [31:0] ref_op(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh,
                                         input logic fl);
    int          amt;
    longint      sa;
    longint      sb;
    logic [63:0] p;
    amt = fl ? int'(sh) : int'(a[4:0]);
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (op)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
      6'h2B: return (a < b) ? 32'd1 : 32'd0;
      6'h00: return b << amt;
      6'h02: return b >> amt;
      6'h03: return 32'(sb >>> amt);
      6'h10: return hi_m;
      6'h12: return lo_m;
      6'h18: begin
        p = 64'(sa * sb);
        hi_m = p[63:32]; lo_m = p[31:0];
        return lo_m;
      end
      6'h19: begin
        p = {32'd0, a} * {32'd0, b};
        hi_m = p[63:32]; lo_m = p[31:0];
        return lo_m;
      end
      6'h1A: begin
        if (b == 32'd0) begin lo_m = 32'hFFFFFFFF; hi_m = a; end
        else begin lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); end
        return lo_m;
      end
      6'h1B: begin
        if (b == 32'd0) begin lo_m = 32'hFFFFFFFF; hi_m = a; end
        else begin lo_m = a / b; hi_m = a % b; end
        return lo_m;
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_md(input logic [5:0] op);
    return (op == 6'h18) || (op == 6'h19) || (op == 6'h1A) || (op == 6'h1B);
  endfunction

  // Issue one request, wait for its o_valid; scrambles operands after accept
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic fl, output logic [31:0] res,
                        output logic zf, output int lat, output int rdy_low);
    int w;
    @(negedge i_clk);
    i_op = op; i_data_a = a; i_data_b = b; i_alu_shamt = sh; i_flag_shamt = fl;
    i_valid = 1'b1;
    w = 0;
    while (!o_ready && w < 200) begin
      @(negedge i_clk);
      w++;
    end
    if (w >= 200) check_val("ready_timeout", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_op = 6'($urandom); i_data_a = $urandom; i_data_b = $urandom;
    i_alu_shamt = 5'($urandom); i_flag_shamt = 1'($urandom);
    lat = 1; rdy_low = 0;
    while (!o_valid && lat < 200) begin
      if (!o_ready) rdy_low++;
      @(negedge i_clk);
      lat++;
    end
    res = o_result;
    zf  = o_alu_zero;
  endtask

  // Run one op and check result, zero flag and latency against the model
  task automatic do_chk(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic fl,
                        output logic [31:0] res, output int lat, output int rdy_low);
    logic [31:0] exp;
    logic        zf;
    exp = ref_op(op, a, b, sh, fl);
    run_op(op, a, b, sh, fl, res, zf, lat, rdy_low);
    check_val({tag, "_res"}, res, exp);
    check_val({tag, "_zero"}, 32'(zf), 32'(exp == 32'd0));
    check_val({tag, "_lat"}, 32'(lat), is_md(op) ? 32'd34 : 32'd1);
  endtask

  logic [5:0]  seq_ops [0:6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
  logic [31:0] seq_exp [0:6] = '{32'd3, 32'd1, 32'd0, 32'd3, 32'd3, 32'hFFFFFFFC, 32'd0};
  logic [5:0]  rnd_ops [0:17] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                                  6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A,
                                  6'h1B, 6'h3F};
  logic [31:0] corner [0:5] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd2};

  function automatic logic [31:0] rnd_operand();
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
    else return $urandom;
  endfunction

  initial begin
    logic [31:0] res;
    logic        zf;
    int          lat;
    int          rl;
    int          vcount;
    int          w;
    logic [5:0]  op;
    checks = 0; errors = 0; hi_m = 32'd0; lo_m = 32'd0;
    i_reset = 1'b1; i_valid = 1'b0; i_op = 6'd0; i_data_a = 32'd0; i_data_b = 32'd0;
    i_alu_shamt = 5'd0; i_flag_shamt = 1'b0;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    check_val("rst_valid", 32'(o_valid), 32'd0);
    check_val("rst_result", o_result, 32'd0);
    check_val("rst_zero", 32'(o_alu_zero), 32'd1);
    check_val("rst_ready", 32'(o_ready), 32'd1);

    // Back-to-back single-cycle ops with A=2, B=1
    i_data_a = 32'd2; i_data_b = 32'd1; vcount = 0;
    for (int i = 0; i < 7; i++) begin
      i_op = seq_ops[i]; i_valid = 1'b1;
      @(negedge i_clk);
      check_val("seq_res", o_result, seq_exp[i]);
      if (o_valid) vcount++;
    end
    i_valid = 1'b0;
    @(negedge i_clk);
    check_val("seq_valid_cnt", 32'(vcount), 32'd7);
    check_val("seq_valid_drop", 32'(o_valid), 32'd0);

    // Shift boundaries
    do_chk("srl31", 6'h02, 32'd0, 32'h80000000, 5'd31, 1'b1, res, lat, rl);
    check_val("srl31_const", res, 32'd1);
    do_chk("sra31", 6'h03, 32'd0, 32'h80000000, 5'd31, 1'b1, res, lat, rl);
    check_val("sra31_const", res, 32'hFFFFFFFF);
    do_chk("srl_rs", 6'h02, 32'd4, 32'h80000000, 5'd31, 1'b0, res, lat, rl);
    check_val("srl_rs_const", res, 32'h08000000);

    // Multiply / divide directed cases
    do_chk("mult", 6'h18, 32'hFFFFFFFD, 32'd7, 5'd0, 1'b0, res, lat, rl);
    check_val("mult_lo", res, 32'hFFFFFFEB);
    check_val("mult_rdy_low", 32'(rl), 32'd33);
    do_chk("mfhi_mult", 6'h10, 32'd0, 32'd0, 5'd0, 1'b0, res, lat, rl);
    check_val("mult_hi", res, 32'hFFFFFFFF);
    do_chk("div", 6'h1A, 32'd7, 32'hFFFFFFFE, 5'd0, 1'b0, res, lat, rl);
    check_val("div_lo", res, 32'hFFFFFFFD);
    do_chk("mfhi_div", 6'h10, 32'd0, 32'd0, 5'd0, 1'b0, res, lat, rl);
    check_val("div_hi", res, 32'd1);
    do_chk("divu0", 6'h1B, 32'd5, 32'd0, 5'd0, 1'b0, res, lat, rl);
    check_val("divu0_lo", res, 32'hFFFFFFFF);
    do_chk("mfhi_divu0", 6'h10, 32'd0, 32'd0, 5'd0, 1'b0, res, lat, rl);
    check_val("divu0_hi", res, 32'd5);
    do_chk("div_ovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 5'd0, 1'b0, res, lat, rl);
    check_val("div_ovf_lo", res, 32'h80000000);
    do_chk("mfhi_ovf", 6'h10, 32'd0, 32'd0, 5'd0, 1'b0, res, lat, rl);
    check_val("div_ovf_hi", res, 32'd0);
    do_chk("undef", 6'h3F, 32'd9, 32'd9, 5'd0, 1'b0, res, lat, rl);
    do_chk("mflo_undef", 6'h12, 32'd0, 32'd0, 5'd0, 1'b0, res, lat, rl);

    // ADD held valid during DIVU: ignored until ready, then accepted
    @(negedge i_clk);
    i_op = 6'h1B; i_data_a = 32'd100; i_data_b = 32'd7; i_valid = 1'b1;
    res = ref_op(6'h1B, 32'd100, 32'd7, 5'd0, 1'b0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_op = 6'h20; i_data_a = 32'd11; i_data_b = 32'd22;
    lat = 1;
    while (!o_valid && lat < 200) begin
      @(negedge i_clk);
      lat++;
    end
    check_val("hold_divu_lat", 32'(lat), 32'd34);
    check_val("hold_divu_res", o_result, res);
    @(negedge i_clk);
    i_valid = 1'b0;
    check_val("hold_add_valid", 32'(o_valid), 32'd1);
    check_val("hold_add_res", o_result, 32'd33);

    // Reset ten cycles into MULTU aborts the operation
    @(negedge i_clk);
    i_op = 6'h19; i_data_a = 32'hFFFFFFFF; i_data_b = 32'h12345678; i_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (9) @(negedge i_clk);
    i_reset = 1'b1;
    #2;
    check_val("arst_ready", 32'(o_ready), 32'd1);
    @(negedge i_clk);
    i_reset = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (o_valid) vcount++;
    end
    check_val("abort_no_valid", 32'(vcount), 32'd0);
    do_chk("mfhi_rst", 6'h10, 32'd0, 32'd0, 5'd0, 1'b0, res, lat, rl);
    check_val("mfhi_rst_const", res, 32'd0);
    do_chk("mflo_rst", 6'h12, 32'd0, 32'd0, 5'd0, 1'b0, res, lat, rl);
    check_val("mflo_rst_const", res, 32'd0);

    // Randomized operations against the model
    for (int n = 0; n < 100; n++) begin
      op = rnd_ops[$urandom_range(0, 17)];
      do_chk("rnd", op, rnd_operand(), rnd_operand(), 5'($urandom), 1'($urandom), res, lat, rl);
    end

    w = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
